// File: rtl/mipi_packet_framer.sv
// mipi_packet_framer: frames a MIPI-style packet on the TX lane.
// The packet is a {SOF,SOF} preamble, then a header, then half-swapped payload
// words, then a one-cycle trailer, then an idle gap.
// Optional build macro FRAMER_HDR_CHECK_EN: rejects a start whose header equals
// {SOF,SOF}. When it is left undefined, hdr_err is tied low.
module mipi_packet_framer #(
  parameter int unsigned PREAMBLE_LEN = 2,
  parameter int unsigned GAP_CYCLES   = 4,
  parameter logic [23:0] SOF          = 24'hEAFF99
) (
  input  logic        tx_pixel_clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [7:0]  dtype,
  input  logic [31:0] dlen,
  input  logic [7:0]  phl_id,
  input  logic [47:0] payload,
  input  logic        payload_valid,
  output logic        payload_ready,
  output logic [47:0] packet,
  output logic        tx_valid,
  output logic        busy,
  output logic        done,
  output logic        underrun,
  output logic        hdr_err
);

  localparam int unsigned PKT_W = 48;
  localparam int unsigned LEN_W = 32;
  localparam int unsigned K_W   = 33;
  localparam int unsigned PRE_W = 4;
  localparam int unsigned GAP_W = 8;
  localparam int unsigned ST_W  = 3;

  localparam logic [ST_W-1:0] ST_IDLE  = 3'd0;
  localparam logic [ST_W-1:0] ST_PRE   = 3'd1;
  localparam logic [ST_W-1:0] ST_HDR   = 3'd2;
  localparam logic [ST_W-1:0] ST_DATA  = 3'd3;
  localparam logic [ST_W-1:0] ST_TRAIL = 3'd4;
  localparam logic [ST_W-1:0] ST_GAP   = 3'd5;

  localparam logic [PKT_W-1:0] SOF_WORD = {SOF, SOF};

  logic [ST_W-1:0]  state_d,    state_q;
  logic [PKT_W-1:0] packet_d,   packet_q;
  logic             tx_valid_d, tx_valid_q;
  logic             done_d,     done_q;
  logic             underrun_d, underrun_q;
  logic [PRE_W-1:0] pre_cnt_d,  pre_cnt_q;
  logic [GAP_W-1:0] gap_cnt_d,  gap_cnt_q;
  logic [K_W-1:0]   k_d,        k_q;
  logic [7:0]       dtype_d,    dtype_q;
  logic [LEN_W-1:0] dlen_d,     dlen_q;
  logic [7:0]       phl_id_d,   phl_id_q;

  logic             more_words_c;
  logic             payload_ready_c;
  logic             hdr_match_c;
  logic [PKT_W-1:0] data_word_c;

  // k is the byte offset of the word on the lane; 33 bits so k+6 never wraps
  assign more_words_c = (k_q + K_W'(6)) < {1'b0, dlen_q};

  // A data word is consumed at the edge that closes HDR (non-empty) or a non-final DATA cycle
  always_comb begin
    payload_ready_c = 1'b0;
    if (state_q == ST_HDR) begin
      payload_ready_c = (dlen_q != '0);
    end else if (state_q == ST_DATA) begin
      payload_ready_c = more_words_c;
    end
  end

  // Half-swapped payload, or an all-zero filler slot on underrun
  assign data_word_c = payload_valid ? {payload[23:0], payload[47:24]} : '0;

`ifdef FRAMER_HDR_CHECK_EN
  logic hdr_err_d, hdr_err_q;

  assign hdr_match_c = ({dtype, dlen, phl_id} == SOF_WORD);

  // Flag a rejected start one cycle after it is seen in IDLE
  always_comb begin
    hdr_err_d = 1'b0;
    if ((state_q == ST_IDLE) && start && hdr_match_c) begin
      hdr_err_d = 1'b1;
    end
  end

  // Rejection pulse register
  always_ff @(posedge tx_pixel_clk or negedge rst_n) begin
    if (!rst_n) begin
      hdr_err_q <= 1'b0;
    end else begin
      hdr_err_q <= hdr_err_d;
    end
  end

  assign hdr_err = hdr_err_q;
`else
  assign hdr_match_c = 1'b0;
  assign hdr_err     = 1'b0;
`endif

  // Next-state and next-output logic for the framing sequence
  always_comb begin
    state_d    = state_q;
    packet_d   = packet_q;
    tx_valid_d = tx_valid_q;
    done_d     = 1'b0;
    underrun_d = 1'b0;
    pre_cnt_d  = pre_cnt_q;
    gap_cnt_d  = gap_cnt_q;
    k_d        = k_q;
    dtype_d    = dtype_q;
    dlen_d     = dlen_q;
    phl_id_d   = phl_id_q;

    case (state_q)
      ST_IDLE: begin
        if (start && !hdr_match_c) begin
          dtype_d    = dtype;
          dlen_d     = dlen;
          phl_id_d   = phl_id;
          packet_d   = SOF_WORD;
          tx_valid_d = 1'b1;
          pre_cnt_d  = PRE_W'(1);
          state_d    = ST_PRE;
        end
      end

      ST_PRE: begin
        if (pre_cnt_q < PRE_W'(PREAMBLE_LEN)) begin
          pre_cnt_d = pre_cnt_q + PRE_W'(1);
        end else begin
          pre_cnt_d = '0;
          packet_d  = {dtype_q, dlen_q, phl_id_q};
          state_d   = ST_HDR;
        end
      end

      ST_HDR: begin
        if (payload_ready_c) begin
          packet_d   = data_word_c;
          tx_valid_d = 1'b1;
          underrun_d = !payload_valid;
          k_d        = '0;
          state_d    = ST_DATA;
        end else begin
          packet_d   = '0;
          tx_valid_d = 1'b0;
          done_d     = 1'b1;
          state_d    = ST_TRAIL;
        end
      end

      ST_DATA: begin
        if (payload_ready_c) begin
          packet_d   = data_word_c;
          tx_valid_d = 1'b1;
          underrun_d = !payload_valid;
          k_d        = k_q + K_W'(6);
        end else begin
          packet_d   = '0;
          tx_valid_d = 1'b0;
          done_d     = 1'b1;
          state_d    = ST_TRAIL;
        end
      end

      ST_TRAIL: begin
        packet_d   = '0;
        tx_valid_d = 1'b0;
        k_d        = '0;
        gap_cnt_d  = GAP_W'(1);
        state_d    = ST_GAP;
      end

      ST_GAP: begin
        packet_d   = '0;
        tx_valid_d = 1'b0;
        if (gap_cnt_q < GAP_W'(GAP_CYCLES)) begin
          gap_cnt_d = gap_cnt_q + GAP_W'(1);
        end else begin
          gap_cnt_d = '0;
          state_d   = ST_IDLE;
        end
      end

      default: begin
        packet_d   = '0;
        tx_valid_d = 1'b0;
        state_d    = ST_IDLE;
      end
    endcase
  end

  // State, output and counter registers; reset aborts any packet in flight
  always_ff @(posedge tx_pixel_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      packet_q   <= '0;
      tx_valid_q <= 1'b0;
      done_q     <= 1'b0;
      underrun_q <= 1'b0;
      pre_cnt_q  <= '0;
      gap_cnt_q  <= '0;
      k_q        <= '0;
      dtype_q    <= '0;
      dlen_q     <= '0;
      phl_id_q   <= '0;
    end else begin
      state_q    <= state_d;
      packet_q   <= packet_d;
      tx_valid_q <= tx_valid_d;
      done_q     <= done_d;
      underrun_q <= underrun_d;
      pre_cnt_q  <= pre_cnt_d;
      gap_cnt_q  <= gap_cnt_d;
      k_q        <= k_d;
      dtype_q    <= dtype_d;
      dlen_q     <= dlen_d;
      phl_id_q   <= phl_id_d;
    end
  end

  assign payload_ready = payload_ready_c;
  assign packet        = packet_q;
  assign tx_valid      = tx_valid_q;
  assign busy          = (state_q != ST_IDLE);
  assign done          = done_q;
  assign underrun      = underrun_q;

endmodule
